hams_merge2: RTL and testbench

// - Two-way streaming merge node of the HAMS sorter. Consumes one sorted run from port A and
//   one from port B, each terminated by a last flag, and emits one sorted run of
//   len(A)+len(B) elements on port M.
// - Sits directly downstream of the hams_pipevld valid stage, which aligns the leaf/FIFO

---
 rtl/hams_pkg.sv | 20 ++
 rtl/hams_merge_outreg.sv | 70 +++++++
 rtl/hams_merge2.sv | 126 ++++++++++++
 tb/tb_hams_merge2.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hams_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hams_pkg                                                     |
// | Description : Shared types and constants for the HAMS merge tree.          |
// |               hams_merge_st_e - merge node state (MERGE / DRAIN_A /        |
// |               DRAIN_B); HAMS_DATA_W - default key width.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hams_pkg;

  localparam int HAMS_DATA_W = 32;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } hams_merge_st_e;

endpackage
`default_nettype wire

// File: rtl/hams_merge_outreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hams_merge_outreg                                            |
// | Description : Registered valid/ready output stage shared by the HAMS       |
// |               merge levels. Loads whenever the register is empty or the    |
// |               downstream accepts (load = !vld | rdy).                      |
// | Ports       : clk, rst_n      - clock, async active-low reset              |
// |               ld_vld_i        - an input element is consumed this cycle    |
// |               ld_data_i/last  - element to load                            |
// |               m_rdy_i         - downstream ready                           |
// |               load_o          - register may take a new element            |
// |               m_vld_o/data/last - registered output                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hams_merge_outreg
  import hams_pkg::*;
#(
  parameter int DATA_W = HAMS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_vld_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  input  logic              m_rdy_i,
  output logic              load_o,
  output logic              m_vld_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign load_o = !vld_q | m_rdy_i;

  // Data and last only change on a real load, so they hold while stalled
  // and keep their old value (harmlessly) once the register drains.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    if (load_o) begin
      vld_d = ld_vld_i;
      if (ld_vld_i) begin
        data_d = ld_data_i;
        last_d = ld_last_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign m_vld_o  = vld_q;
  assign m_data_o = data_q;
  assign m_last_o = last_q;

endmodule
`default_nettype wire

// File: rtl/hams_merge2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hams_merge2                                                  |
// | Description : Two-way streaming merge node. Merges one sorted run from A   |
// |               and one from B (each closed by a last flag) into a single    |
// |               sorted run on M, one element per cycle when M is not stalled.|
// | Ports       : clk, rst_n              - clock, async active-low reset      |
// |               a_vld_i/a_data_i/a_last_i, a_rdy_o - input stream A          |
// |               b_vld_i/b_data_i/b_last_i, b_rdy_o - input stream B          |
// |               m_vld_o/m_data_o/m_last_o, m_rdy_i - merged output (regd)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hams_merge2
  import hams_pkg::*;
#(
  parameter int DATA_W    = HAMS_DATA_W,
  parameter bit ASCENDING = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_vld_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_last_i,
  output logic              a_rdy_o,
  input  logic              b_vld_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_last_i,
  output logic              b_rdy_o,
  output logic              m_vld_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_rdy_i
);

  hams_merge_st_e    state_q;
  logic              sel_a;
  logic              load;
  logic              a_take;
  logic              b_take;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  // Ties select A so equal keys keep their A-before-B order (stable merge).
  generate
    if (ASCENDING) begin : g_asc
      assign sel_a = (a_data_i <= b_data_i);
    end else begin : g_desc
      assign sel_a = (a_data_i >= b_data_i);
    end
  endgenerate

  // Readiness is gated by load, so a stalled M register blocks both inputs.
  always_comb begin
    a_rdy_o = 1'b0;
    b_rdy_o = 1'b0;
    ld_last = 1'b0;
    case (state_q)
      MERGE: begin
        a_rdy_o = load & a_vld_i & b_vld_i & sel_a;
        b_rdy_o = load & a_vld_i & b_vld_i & !sel_a;
      end
      DRAIN_A: begin
        a_rdy_o = load;
        ld_last = a_last_i;
      end
      DRAIN_B: begin
        b_rdy_o = load;
        ld_last = b_last_i;
      end
      default: begin
        a_rdy_o = 1'b0;
        b_rdy_o = 1'b0;
      end
    endcase
  end

  assign a_take  = a_vld_i & a_rdy_o;
  assign b_take  = b_vld_i & b_rdy_o;
  assign ld_data = a_take ? a_data_i : b_data_i;

  // The last element of one run flips to draining the other run; the last
  // element of the drained run closes the pair and reopens MERGE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MERGE;
    end else begin
      case (state_q)
        MERGE: begin
          if (a_take && a_last_i) begin
            state_q <= DRAIN_B;
          end else if (b_take && b_last_i) begin
            state_q <= DRAIN_A;
          end
        end
        DRAIN_A: begin
          if (a_take && a_last_i) begin
            state_q <= MERGE;
          end
        end
        DRAIN_B: begin
          if (b_take && b_last_i) begin
            state_q <= MERGE;
          end
        end
        default: state_q <= MERGE;
      endcase
    end
  end

  hams_merge_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_vld_i  (a_take | b_take),
    .ld_data_i (ld_data),
    .ld_last_i (ld_last),
    .m_rdy_i   (m_rdy_i),
    .load_o    (load),
    .m_vld_o   (m_vld_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_hams_merge2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hams_merge2                                               |
// | Description : Self-checking bench for hams_merge2. A cycle table covers    |
// |               the basic ascending merge; queue-driven sequences cover      |
// |               ties, backpressure, back-to-back runs, descending order and  |
// |               asynchronous reset mid-run.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hams_merge2;

  logic        clk;
  logic        rst_n;
  logic        a_vld, a_last, b_vld, b_last, m_rdy;
  logic [31:0] a_data, b_data;
  logic        a_rdy, b_rdy, m_vld, m_last;
  logic [31:0] m_data;
  logic        d_a_rdy, d_b_rdy, d_m_vld, d_m_last;
  logic [31:0] d_m_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Selects which DUT the input-hold assertions and the sequences observe.
  bit obs_desc = 1'b0;

  logic [32:0] qa[$];   // {last, data}
  logic [32:0] qb[$];
  logic [33:0] expq[$]; // {last, src(1=A), data}

  hams_merge2 #(.DATA_W(32), .ASCENDING(1'b1)) u_asc (
    .clk(clk), .rst_n(rst_n),
    .a_vld_i(a_vld), .a_data_i(a_data), .a_last_i(a_last), .a_rdy_o(a_rdy),
    .b_vld_i(b_vld), .b_data_i(b_data), .b_last_i(b_last), .b_rdy_o(b_rdy),
    .m_vld_o(m_vld), .m_data_o(m_data), .m_last_o(m_last), .m_rdy_i(m_rdy)
  );

  hams_merge2 #(.DATA_W(32), .ASCENDING(1'b0)) u_desc (
    .clk(clk), .rst_n(rst_n),
    .a_vld_i(a_vld), .a_data_i(a_data), .a_last_i(a_last), .a_rdy_o(d_a_rdy),
    .b_vld_i(b_vld), .b_data_i(b_data), .b_last_i(b_last), .b_rdy_o(d_b_rdy),
    .m_vld_o(d_m_vld), .m_data_o(d_m_data), .m_last_o(d_m_last), .m_rdy_i(m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire obs_a_rdy = obs_desc ? d_a_rdy : a_rdy;
  wire obs_b_rdy = obs_desc ? d_b_rdy : b_rdy;

  // Source-side protocol: a pending element must stay put until consumed.
  a_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
      (a_vld && !obs_a_rdy) |=> (a_vld && $stable(a_data) && $stable(a_last)))
    else begin n_fail++; $display("FAIL hold_a: A input changed before consume"); end
  a_hold_b: assert property (@(posedge clk) disable iff (!rst_n)
      (b_vld && !obs_b_rdy) |=> (b_vld && $stable(b_data) && $stable(b_last)))
    else begin n_fail++; $display("FAIL hold_b: B input changed before consume"); end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk(input logic last, input logic src, input logic [31:0] d);
    return {last, src, d};
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    a_vld  = 1'b0; a_data = '0; a_last = 1'b0;
    b_vld  = 1'b0; b_data = '0; b_last = 1'b0;
    m_rdy  = 1'b1;
    qa.delete(); qb.delete(); expq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives qa/qb, collects M, compares against expq in order.
  // mode 0: m_rdy always 1 (also checks no bubble); mode 1: m_rdy 1,0,0 repeating.
  // stop_after > 0 leaves the run early after that many outputs.
  task automatic run_seq(input string tag, input int mode, input int stop_after);
    bit          srcq[$];
    bit          stalled_prev = 1'b0;
    logic [32:0] held = '0;
    int          cyc = 0;
    int          rcv = 0;
    int          bubbles = 0;
    bit          ca, cb, src;
    logic        ov, ol, oar, obr;
    logic [31:0] od;
    while (rcv < expq.size()) begin
      @(negedge clk);
      a_vld  = (qa.size() > 0);
      a_data = a_vld ? qa[0][31:0] : 32'd0;
      a_last = a_vld ? qa[0][32] : 1'b0;
      b_vld  = (qb.size() > 0);
      b_data = b_vld ? qb[0][31:0] : 32'd0;
      b_last = b_vld ? qb[0][32] : 1'b0;
      m_rdy  = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      ov  = obs_desc ? d_m_vld  : m_vld;
      od  = obs_desc ? d_m_data : m_data;
      ol  = obs_desc ? d_m_last : m_last;
      oar = obs_desc ? d_a_rdy  : a_rdy;
      obr = obs_desc ? d_b_rdy  : b_rdy;
      if (stalled_prev) begin
        chk({tag, "_stall_vld"}, 64'(ov), 64'd1);
        chk({tag, "_stall_data"}, 64'({ol, od}), 64'(held));
      end
      if (ov && !m_rdy) begin
        chk({tag, "_stall_rdy"}, 64'({oar, obr}), 64'd0);
        stalled_prev = 1'b1;
        held = {ol, od};
      end else begin
        stalled_prev = 1'b0;
      end
      if (mode == 0 && rcv > 0 && !ov) bubbles++;
      if (ov && m_rdy) begin
        src = (srcq.size() > 0) ? srcq.pop_front() : 1'b0;
        chk($sformatf("%s_out%0d", tag, rcv), 64'({ol, src, od}), 64'(expq[rcv]));
        rcv++;
      end
      ca = a_vld & oar;
      cb = b_vld & obr;
      @(posedge clk);
      if (ca) begin void'(qa.pop_front()); srcq.push_back(1'b1); end
      if (cb) begin void'(qb.pop_front()); srcq.push_back(1'b0); end
      cyc++;
      if (stop_after > 0 && rcv == stop_after) break;
      if (cyc > 200) begin
        n_chk++; n_fail++;
        $display("FAIL %s_timeout: got %0d outputs expected %0d", tag, rcv, expq.size());
        break;
      end
    end
    if (stop_after == 0) begin
      @(negedge clk);
      a_vld = 1'b0; b_vld = 1'b0; m_rdy = 1'b1;
      #1;
      chk({tag, "_idle_after"}, 64'(obs_desc ? d_m_vld : m_vld), 64'd0);
      chk({tag, "_inputs_drained"}, 64'(qa.size() + qb.size()), 64'd0);
      if (mode == 0) chk({tag, "_bubbles"}, 64'(bubbles), 64'd0);
    end
  endtask

  typedef struct {
    logic        a_vld; logic [31:0] a_data; logic a_last;
    logic        b_vld; logic [31:0] b_data; logic b_last;
    logic        m_rdy;
    logic        x_a_rdy; logic x_b_rdy;
    logic        x_m_vld; logic [31:0] x_m_data; logic x_m_last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Basic merge A=[1,4,7L] B=[2,3,9L], one row per cycle:
    // inputs, ready before the edge, M after the edge.
    tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0};
    tbl[1] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0};
    tbl[2] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0};
    tbl[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4, 1'b0};
    tbl[4] = '{1'b1, 32'd7, 1'b1, 1'b1, 32'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd9, 1'b1};
    tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};

    rst_n = 1'b0;
    a_vld = 1'b0; a_data = '0; a_last = 1'b0;
    b_vld = 1'b0; b_data = '0; b_last = 1'b0;
    m_rdy = 1'b1;
    #2;
    chk("reset_m_vld",  64'(m_vld),  64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_m_last", 64'(m_last), 64'd0);
    chk("reset_desc",   64'({d_m_vld, d_m_last, d_m_data}), 64'd0);
    do_reset();

    // Table-driven basic merge on the ascending node.
    obs_desc = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_vld = tbl[i].a_vld; a_data = tbl[i].a_data; a_last = tbl[i].a_last;
      b_vld = tbl[i].b_vld; b_data = tbl[i].b_data; b_last = tbl[i].b_last;
      m_rdy = tbl[i].m_rdy;
      #1;
      chk($sformatf("tbl%0d_a_rdy", i), 64'(a_rdy), 64'(tbl[i].x_a_rdy));
      chk($sformatf("tbl%0d_b_rdy", i), 64'(b_rdy), 64'(tbl[i].x_b_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_m_vld", i), 64'(m_vld), 64'(tbl[i].x_m_vld));
      if (tbl[i].x_m_vld) begin
        chk($sformatf("tbl%0d_m_data", i), 64'(m_data), 64'(tbl[i].x_m_data));
        chk($sformatf("tbl%0d_m_last", i), 64'(m_last), 64'(tbl[i].x_m_last));
      end
    end

    // Tie: equal keys, A elements must leave before the B element.
    do_reset();
    qa = '{{1'b0, 32'd5}, {1'b1, 32'd5}};
    qb = '{{1'b1, 32'd5}};
    expq = '{mk(0, 1, 5), mk(0, 1, 5), mk(1, 0, 5)};
    run_seq("tie", 0, 0);

    // Backpressure on the basic data, m_rdy 1,0,0 repeating.
    do_reset();
    qa = '{{1'b0, 32'd1}, {1'b0, 32'd4}, {1'b1, 32'd7}};
    qb = '{{1'b0, 32'd2}, {1'b0, 32'd3}, {1'b1, 32'd9}};
    expq = '{mk(0, 1, 1), mk(0, 0, 2), mk(0, 0, 3), mk(0, 1, 4), mk(0, 1, 7), mk(1, 0, 9)};
    run_seq("bp", 1, 0);

    // Single-element run plus a back-to-back second run pair.
    do_reset();
    qa = '{{1'b1, 32'd8}, {1'b1, 32'd0}};
    qb = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b1, 32'd3}, {1'b1, 32'd6}};
    expq = '{mk(0, 0, 1), mk(0, 0, 2), mk(0, 0, 3), mk(1, 1, 8), mk(0, 1, 0), mk(1, 0, 6)};
    run_seq("b2b", 0, 0);

    // Descending node.
    do_reset();
    obs_desc = 1'b1;
    qa = '{{1'b0, 32'd9}, {1'b1, 32'd3}};
    qb = '{{1'b0, 32'd7}, {1'b1, 32'd1}};
    expq = '{mk(0, 1, 9), mk(0, 0, 7), mk(0, 1, 3), mk(1, 0, 1)};
    run_seq("desc", 0, 0);
    obs_desc = 1'b0;

    // Asynchronous reset after two outputs of the basic merge.
    do_reset();
    qa = '{{1'b0, 32'd1}, {1'b0, 32'd4}, {1'b1, 32'd7}};
    qb = '{{1'b0, 32'd2}, {1'b0, 32'd3}, {1'b1, 32'd9}};
    expq = '{mk(0, 1, 1), mk(0, 0, 2), mk(0, 0, 3), mk(0, 1, 4), mk(0, 1, 7), mk(1, 0, 9)};
    run_seq("pre_rst", 0, 2);
    #2;
    chk("pre_rst_m_vld", 64'(m_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_vld", 64'(m_vld), 64'd0);
    do_reset();
    qa = '{{1'b1, 32'd2}};
    qb = '{{1'b1, 32'd1}};
    expq = '{mk(0, 0, 1), mk(1, 1, 2)};
    run_seq("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
